// File: rtl/blit_scheduler.sv
// blit_scheduler: round-robin arbiter that sequences one rectangular sprite blit at a time onto the VGA adapter port.
// Optional feature: define BLIT_TRANSPARENT_EN to suppress plots whose ROM colour equals TRANSP_COLOUR.
module blit_scheduler #(
  parameter int NREQ = 2,
  parameter int SPR_W = 80,
  parameter int SPR_H = 120,
  parameter int ADDR_W = 14,
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240,
  parameter logic [2:0] TRANSP_COLOUR = 3'b101
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [9*NREQ-1:0]        req_x,
  input  logic [8*NREQ-1:0]        req_y,
  input  logic [ADDR_W*NREQ-1:0]   req_base,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [2:0]               rom_data,
  output logic [8:0]               vga_x,
  output logic [7:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SPR_W + 1);
  localparam int RW = $clog2(SPR_H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(SPR_H - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NREQ - 1);
  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [8:0] YM = 9'(Y_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state;
  logic [PW-1:0] ptr, sel, win;
  logic any;
  logic [2*NREQ-1:0] rot;
  logic [8:0] x;
  logic [7:0] y;
  logic [CW-1:0] col, col_d;
  logic [RW-1:0] row, row_d;
  logic valid_d;
  logic [9:0] x_sum;
  logic [8:0] y_sum;
  logic in_bounds;

  assign rot = {req, req} >> ptr;

  // Round-robin pick: the lowest offset from ptr with a pending request wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win = PW'((int'(ptr) + k) >= NREQ ? int'(ptr) + k - NREQ : int'(ptr) + k);
        any = 1'b1;
      end
    end
  end

  // Blit sequencer: grant, row-major address scan, pipeline drain, completion pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      gnt <= '0;
      done <= '0;
      busy <= 1'b0;
      rom_addr <= '0;
      x <= '0;
      y <= '0;
      col <= '0;
      row <= '0;
      col_d <= '0;
      row_d <= '0;
      valid_d <= 1'b0;
    end else begin
      gnt <= '0;
      done <= '0;
      valid_d <= state == SCAN;
      col_d <= col;
      row_d <= row;
      case (state)
        IDLE: if (any) begin
          state <= SCAN;
          sel <= win;
          ptr <= win == P_LAST ? '0 : win + 1'b1;
          gnt <= NREQ'(1) << win;
          busy <= 1'b1;
          x <= req_x[9*win +: 9];
          y <= req_y[8*win +: 8];
          rom_addr <= req_base[ADDR_W*win +: ADDR_W];
          col <= '0;
          row <= '0;
        end
        SCAN: begin
          rom_addr <= rom_addr + 1'b1;
          col <= col == C_LAST ? '0 : col + 1'b1;
          if (col == C_LAST) begin
            row <= row + 1'b1;
            if (row == R_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DONE;
          done <= NREQ'(1) << sel;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

  assign x_sum = {1'b0, x} + 10'(col_d);
  assign y_sum = {1'b0, y} + 9'(row_d);
  assign vga_x = x_sum[8:0];
  assign vga_y = y_sum[7:0];
  assign vga_colour = valid_d ? rom_data : 3'b000;
  assign in_bounds = valid_d && x_sum < XM && y_sum < YM;

`ifdef BLIT_TRANSPARENT_EN
  assign vga_plot = in_bounds && rom_data != TRANSP_COLOUR;
`else
  logic unused_transp;
  assign unused_transp = ^TRANSP_COLOUR;
  assign vga_plot = in_bounds;
`endif
endmodule
